trace_monitor: RTL and testbench
================================

Name: trace_monitor

Overview:
- Synthesizable, parametrised execution-trace monitor that sits beside the DataPath and taps its per-cycle PC, next-PC, instruction and register-write-enable signals.
- Records these into a circular trace buffer, counts executed cycles, and halts capture on a cycle limit or a PC breakpoint.
- Exposes a registered readout port so a bench or debug host can dump the last DEPTH cycles after a halt.
- Replaces hand-written per-cycle display-and-stop logic with a reusable, checkable block.

Parameters:
- WIDTH, 32: width of PC, next-PC and instruction fields.
- DEPTH, 16: trace entries; must be a power of two, minimum 2.
- MAX_CYCLES, 30: captured-cycle limit that triggers a halt; 0 disables the limit.
- NUM_BP, 2: number of PC breakpoint comparators, 1 to 8.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: capture qualifier; a cycle is captured only when high.
- pc_in, input, WIDTH: current PC (DataPath pcQ).
- pc_next_in, input, WIDTH: next PC (DataPath pcD).
- instr_in, input, WIDTH: current instruction.
- reg_we_in, input, 1: register-write enable for the current instruction.
- bp_addr, input, NUM_BP*WIDTH: breakpoint addresses; slot k occupies bits [k*WIDTH +: WIDTH].
- bp_valid, input, NUM_BP: per-slot breakpoint enable.
- rd_req, input, 1: readout request.
- rd_idx, input, $clog2(DEPTH): logical index to read; 0 = oldest valid entry.
- rd_valid, output, 1: readout data valid.
- rd_pc, output, WIDTH: PC of the read entry.
- rd_pc_next, output, WIDTH: next PC of the read entry.
- rd_instr, output, WIDTH: instruction of the read entry.
- rd_we, output, 1: reg-write enable of the read entry.
- entries, output, $clog2(DEPTH)+1: number of valid entries, saturating at DEPTH.
- cycle_count, output, 32: number of captured cycles.
- overflow, output, 1: sticky flag; set once an entry has been overwritten.
- halted, output, 1: high while the FSM is in HALT.
- halt_cause, output, 2: 01 = cycle limit, 10 = breakpoint, 11 = both in the same cycle, 00 = not halted.

Behaviour:
- Reset, synchronous, takes priority over everything:
  - FSM enters RUN.
  - Write pointer, entries, cycle_count, overflow, halted, halt_cause and rd_valid go to 0.
  - rd_pc, rd_pc_next, rd_instr and rd_we go to 0.
  - Buffer contents need not be cleared; entries=0 makes them unreachable.
  - Reset mid-readout or mid-capture discards everything.
- FSM has two states, RUN and HALT.
- RUN, on a rising edge with enable=1 (a capture):
  - Write {pc_in, pc_next_in, instr_in, reg_we_in} at wr_ptr; wr_ptr = (wr_ptr+1) mod DEPTH.
  - cycle_count increments, saturating at 2^32-1.
  - entries increments while below DEPTH; if entries==DEPTH, set overflow and overwrite the oldest entry.
- Halt evaluation, same edge, only for a captured cycle:
  - lim = (MAX_CYCLES!=0) && (cycle_count+1 == MAX_CYCLES).
  - bp = OR over k of (bp_valid[k] && pc_in == bp slot k).
  - If lim or bp: the cycle is still captured, then go to HALT with halt_cause = {bp, lim} and halted=1 from the next cycle.
- RUN with enable=0: no write, no count, no halt check.
- HALT: no captures regardless of enable. cycle_count, entries, overflow and halt_cause are frozen. Only reset exits HALT.
- Readout, in any state:
  - rd_req sampled at edge N; outputs are valid after edge N, so latency is 1 cycle.
  - Physical slot = (wr_ptr - entries + rd_idx) mod DEPTH, using pre-edge values.
  - If rd_idx < entries: rd_valid=1 and data = stored entry.
  - Else: rd_valid=0 and data outputs = 0.
  - rd_valid stays high for 1 cycle per request; back-to-back requests give one result per cycle.
  - If a read and a capture hit the same physical slot on the same edge, the read returns the pre-write contents.
- Widths: all comparisons are full WIDTH. entries is wide enough to hold DEPTH exactly.

Test Plan:
- Reset, then enable=1, pc_in = 0,4,8,... each cycle, MAX_CYCLES=30, no breakpoints -> halted=1 after the 30th capture; cycle_count=30, halt_cause=01, entries=16, overflow=1. Reading rd_idx=0 returns pc 0x38 (capture 15); rd_idx=15 returns pc 0x74.
- bp_addr slot0=0x10, bp_valid=01, pc stepping by 4 from 0 -> halt after capturing pc 0x10; cycle_count=5, entries=5, halt_cause=10, overflow=0. After the halt, toggling enable changes nothing.
- MAX_CYCLES=30 and bp=0x74 (the 30th PC) -> halt_cause=11 on the same cycle.
- Read rd_idx=7 with entries=5 -> rd_valid=0 and data 0. Issue rd_req on 3 consecutive cycles for idx 0,1,2 -> 3 consecutive valid results in order.
- enable toggling 1,0,1,0 over 4 cycles -> cycle_count=2, entries=2. Assert reset while halted -> all outputs 0 next cycle and capture resumes.
- MAX_CYCLES=0, run 100 cycles -> halted stays 0, cycle_count=100, entries=16, overflow=1. A read colliding with the slot being written returns the old entry.

Source files
------------

// File: rtl/trace_monitor.sv
// Execution-trace monitor: captures per-cycle PC/next-PC/instruction/reg-write into a
// circular buffer, counts captured cycles and halts on a cycle limit or PC breakpoint.
module trace_monitor #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 30,
  parameter int NUM_BP     = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          pc_in,
  input  logic [WIDTH-1:0]          pc_next_in,
  input  logic [WIDTH-1:0]          instr_in,
  input  logic                      reg_we_in,
  input  logic [NUM_BP*WIDTH-1:0]   bp_addr,
  input  logic [NUM_BP-1:0]         bp_valid,
  input  logic                      rd_req,
  input  logic [$clog2(DEPTH)-1:0]  rd_idx,
  output logic                      rd_valid,
  output logic [WIDTH-1:0]          rd_pc,
  output logic [WIDTH-1:0]          rd_pc_next,
  output logic [WIDTH-1:0]          rd_instr,
  output logic                      rd_we,
  output logic [$clog2(DEPTH):0]    entries,
  output logic [31:0]               cycle_count,
  output logic                      overflow,
  output logic                      halted,
  output logic [1:0]                halt_cause
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 * WIDTH + 1;
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_entries;
  logic [31:0]     r_cycle_count;
  logic            r_overflow;
  logic [1:0]      r_halt_cause;
  logic            r_rd_valid;
  logic [EW-1:0]   r_rd_entry;

  logic            w_capture;
  logic            w_lim;
  logic            w_bp;
  logic [31:0]     w_cnt_inc;
  logic [AW-1:0]   w_rd_slot;
  logic            w_rd_hit;

  assign w_capture = (r_state == ST_RUN) && enable;
  assign w_cnt_inc = r_cycle_count + 32'd1;
  assign w_lim     = (MAX_CYCLES != 0) && (w_cnt_inc == 32'(MAX_CYCLES));
  // Oldest valid entry sits 'entries' slots behind the write pointer.
  assign w_rd_slot = r_wr_ptr - r_entries[AW-1:0] + rd_idx;
  assign w_rd_hit  = ({1'b0, rd_idx} < r_entries);

  always_comb begin
    w_bp = 1'b0;
    for (int k = 0; k < NUM_BP; k++) begin
      if (bp_valid[k] && (pc_in == bp_addr[k*WIDTH +: WIDTH])) begin
        w_bp = 1'b1;
      end else begin
        w_bp = w_bp;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_capture && (w_lim || w_bp)) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Trace storage has no reset; entries=0 hides stale contents.
  always_ff @(posedge clock) begin
    if (w_capture && !reset) begin
      r_mem[r_wr_ptr] <= {pc_in, pc_next_in, instr_in, reg_we_in};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_entries     <= '0;
      r_cycle_count <= 32'd0;
      r_overflow    <= 1'b0;
      r_halt_cause  <= 2'b00;
      r_rd_valid    <= 1'b0;
      r_rd_entry    <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_cycle_count != 32'hFFFF_FFFF) begin
          r_cycle_count <= w_cnt_inc;
        end
        if (r_entries == L_FULL) begin
          r_overflow <= 1'b1;
        end else begin
          r_entries <= r_entries + (AW+1)'(1);
        end
        if (w_lim || w_bp) begin
          r_halt_cause <= {w_bp, w_lim};
        end
      end
      // Reads see pre-edge memory, so a colliding capture returns the old entry.
      if (rd_req) begin
        r_rd_valid <= w_rd_hit;
        r_rd_entry <= w_rd_hit ? r_mem[w_rd_slot] : '0;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign rd_valid    = r_rd_valid;
  assign rd_pc       = r_rd_entry[EW-1 -: WIDTH];
  assign rd_pc_next  = r_rd_entry[2*WIDTH -: WIDTH];
  assign rd_instr    = r_rd_entry[WIDTH:1];
  assign rd_we       = r_rd_entry[0];
  assign entries     = r_entries;
  assign cycle_count = r_cycle_count;
  assign overflow    = r_overflow;
  assign halted      = (r_state == ST_HALT);
  assign halt_cause  = r_halt_cause;

endmodule

// File: tb/tb_trace_monitor.sv
// Scoreboard bench for trace_monitor: two instances (cycle limit 30 and limit disabled)
// share stimulus and are checked against a list-based reference model.
module tb_trace_monitor;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcn;
    logic [31:0] ins;
    logic        we;
  } entry_t;

  typedef struct packed {
    logic   v;
    entry_t e;
  } rdexp_t;

  logic        clock = 1'b0;
  logic        reset, enable, reg_we_in, rd_req;
  logic [31:0] pc_in, pc_next_in, instr_in;
  logic [63:0] bp_addr;
  logic [1:0]  bp_valid;
  logic [3:0]  rd_idx;

  logic        o0_rd_valid, o1_rd_valid, o0_rd_we, o1_rd_we;
  logic [31:0] o0_rd_pc, o1_rd_pc, o0_rd_pc_next, o1_rd_pc_next, o0_rd_instr, o1_rd_instr;
  logic [4:0]  o0_entries, o1_entries;
  logic [31:0] o0_cycle_count, o1_cycle_count;
  logic        o0_overflow, o1_overflow, o0_halted, o1_halted;
  logic [1:0]  o0_halt_cause, o1_halt_cause;

  int n_tests = 0;
  int n_fail  = 0;

  entry_t      m_buf [2][16];
  int          m_n   [2];
  logic [31:0] m_cnt [2];
  logic        m_ovf [2];
  logic        m_halt[2];
  logic [1:0]  m_cause[2];
  rdexp_t      q0[$];
  rdexp_t      q1[$];
  logic [31:0] pcs [100];
  logic        rst_r;

  always #5 clock = ~clock;

  trace_monitor #(.WIDTH(32), .DEPTH(16), .MAX_CYCLES(30), .NUM_BP(2)) u_lim (
    .clock(clock), .reset(reset), .enable(enable), .pc_in(pc_in), .pc_next_in(pc_next_in),
    .instr_in(instr_in), .reg_we_in(reg_we_in), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(o0_rd_valid), .rd_pc(o0_rd_pc),
    .rd_pc_next(o0_rd_pc_next), .rd_instr(o0_rd_instr), .rd_we(o0_rd_we),
    .entries(o0_entries), .cycle_count(o0_cycle_count), .overflow(o0_overflow),
    .halted(o0_halted), .halt_cause(o0_halt_cause));

  trace_monitor #(.WIDTH(32), .DEPTH(16), .MAX_CYCLES(0), .NUM_BP(2)) u_free (
    .clock(clock), .reset(reset), .enable(enable), .pc_in(pc_in), .pc_next_in(pc_next_in),
    .instr_in(instr_in), .reg_we_in(reg_we_in), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(o1_rd_valid), .rd_pc(o1_rd_pc),
    .rd_pc_next(o1_rd_pc_next), .rd_instr(o1_rd_instr), .rd_we(o1_rd_we),
    .entries(o1_entries), .cycle_count(o1_cycle_count), .overflow(o1_overflow),
    .halted(o1_halted), .halt_cause(o1_halt_cause));

  task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  // Reference model: trace kept as an ordered list, oldest first.
  task automatic model_edge(input int k);
    entry_t e;
    rdexp_t x;
    logic   lim, bp;
    int     maxc;
    maxc = (k == 0) ? 30 : 0;
    if (reset) begin
      m_n[k] = 0; m_cnt[k] = 32'd0; m_ovf[k] = 1'b0; m_halt[k] = 1'b0; m_cause[k] = 2'b00;
      return;
    end
    if (rd_req) begin
      x.v = (int'(rd_idx) < m_n[k]);
      x.e = x.v ? m_buf[k][rd_idx] : '0;
      if (k == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
    if (!m_halt[k] && enable) begin
      e   = '{pc_in, pc_next_in, instr_in, reg_we_in};
      lim = (maxc != 0) && (longint'(m_cnt[k]) + 1 == longint'(maxc));
      bp  = 1'b0;
      for (int j = 0; j < 2; j++)
        if (bp_valid[j] && pc_in == bp_addr[j*32 +: 32]) bp = 1'b1;
      if (m_n[k] == 16) begin
        for (int i = 0; i < 15; i++) m_buf[k][i] = m_buf[k][i+1];
        m_buf[k][15] = e;
        m_ovf[k] = 1'b1;
      end else begin
        m_buf[k][m_n[k]] = e;
        m_n[k]++;
      end
      if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 32'd1;
      if (lim || bp) begin
        m_halt[k]  = 1'b1;
        m_cause[k] = {bp, lim};
      end
    end
  endtask

  task automatic cyc(input logic en, input logic [31:0] pc, input logic req, input logic [3:0] idx, input logic rst);
    reset = rst; enable = en; pc_in = pc; pc_next_in = pc + 32'd4;
    instr_in = $urandom; reg_we_in = 1'($urandom_range(0, 1));
    rd_req = req; rd_idx = idx;
    model_edge(0);
    model_edge(1);
    @(posedge clock);
    #3;
  endtask

  task automatic check_inst(input int k, input logic rv, input entry_t re, input logic [4:0] ent,
                            input logic [31:0] cc, input logic ovf, input logic hl, input logic [1:0] hc);
    rdexp_t x;
    logic   have;
    chk("entries",     k, 128'(ent), 128'(m_n[k]));
    chk("cycle_count", k, 128'(cc),  128'(m_cnt[k]));
    chk("overflow",    k, 128'(ovf), 128'(m_ovf[k]));
    chk("halted",      k, 128'(hl),  128'(m_halt[k]));
    chk("halt_cause",  k, 128'(hc),  128'(m_halt[k] ? m_cause[k] : 2'b00));
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) begin
      if (k == 0) x = q0.pop_front();
      else        x = q1.pop_front();
      chk("rd_valid", k, 128'(rv), 128'(x.v));
      chk("rd_data",  k, 128'(re), 128'(x.e));
    end else begin
      chk("rd_idle_valid", k, 128'(rv), 128'(1'b0));
    end
  endtask

  // Monitor: compares both instances one time unit after every rising edge.
  always @(posedge clock) begin
    #1;
    check_inst(0, o0_rd_valid, '{o0_rd_pc, o0_rd_pc_next, o0_rd_instr, o0_rd_we},
               o0_entries, o0_cycle_count, o0_overflow, o0_halted, o0_halt_cause);
    check_inst(1, o1_rd_valid, '{o1_rd_pc, o1_rd_pc_next, o1_rd_instr, o1_rd_we},
               o1_entries, o1_cycle_count, o1_overflow, o1_halted, o1_halt_cause);
  end

  initial begin
    bp_addr = 64'd0; bp_valid = 2'b00;
    cyc(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    chk("reset_entries", 0, 128'(o0_entries), 128'(5'd0));

    // Cycle limit after 30 captures.
    for (int i = 0; i < 30; i++) cyc(1'b1, 32'(i * 4), 1'b0, 4'd0, 1'b0);
    chk("lim_halted", 0, 128'(o0_halted), 128'(1'b1));
    chk("lim_count",  0, 128'(o0_cycle_count), 128'(32'd30));
    chk("lim_cause",  0, 128'(o0_halt_cause), 128'(2'b01));
    chk("lim_ovf",    0, 128'(o0_overflow), 128'(1'b1));
    chk("free_running", 1, 128'(o1_halted), 128'(1'b0));
    cyc(1'b0, 32'd0, 1'b1, 4'd0, 1'b0);
    chk("lim_rd0_pc", 0, 128'(o0_rd_pc), 128'(32'h38));
    cyc(1'b0, 32'd0, 1'b1, 4'd15, 1'b0);
    chk("lim_rd15_pc", 0, 128'(o0_rd_pc), 128'(32'h74));

    // Breakpoint at 0x10, then enable toggling while halted.
    cyc(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    bp_addr = {32'hDEAD_BEEF, 32'h10}; bp_valid = 2'b01;
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(i * 4), 1'b0, 4'd0, 1'b0);
    chk("bp_count", 0, 128'(o0_cycle_count), 128'(32'd5));
    chk("bp_cause", 1, 128'(o1_halt_cause), 128'(2'b10));
    for (int i = 5; i < 9; i++) cyc(1'(i % 2), 32'(i * 4), 1'b0, 4'd0, 1'b0);
    chk("bp_frozen_cnt", 0, 128'(o0_cycle_count), 128'(32'd5));
    chk("bp_frozen_ent", 0, 128'(o0_entries), 128'(5'd5));
    cyc(1'b1, 32'd0, 1'b1, 4'd7, 1'b0);
    chk("rd_oob_valid", 0, 128'(o0_rd_valid), 128'(1'b0));
    chk("rd_oob_pc",    0, 128'(o0_rd_pc), 128'(32'd0));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'd0, 1'b1, 4'(i), 1'b0);
      chk("rd_b2b_valid", 0, 128'(o0_rd_valid), 128'(1'b1));
      chk("rd_b2b_pc",    0, 128'(o0_rd_pc), 128'(32'(i * 4)));
    end

    // Limit and breakpoint coincide on the 30th capture.
    cyc(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    bp_addr = {32'hDEAD_BEEF, 32'h74}; bp_valid = 2'b11;
    for (int i = 0; i < 30; i++) cyc(1'b1, 32'(i * 4), 1'b0, 4'd0, 1'b0);
    chk("both_cause", 0, 128'(o0_halt_cause), 128'(2'b11));
    chk("bp30_cause", 1, 128'(o1_halt_cause), 128'(2'b10));
    cyc(1'b1, 32'd0, 1'b0, 4'd0, 1'b1);
    chk("rst_halted", 0, 128'(o0_halted), 128'(1'b0));
    chk("rst_count",  0, 128'(o0_cycle_count), 128'(32'd0));
    cyc(1'b1, 32'h100, 1'b0, 4'd0, 1'b0);
    chk("resume_count", 0, 128'(o0_cycle_count), 128'(32'd1));

    // Enable pattern 1,0,1,0.
    bp_valid = 2'b00;
    cyc(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'((i + 1) % 2), 32'(i * 4), 1'b0, 4'd0, 1'b0);
    chk("toggle_count",   0, 128'(o0_cycle_count), 128'(32'd2));
    chk("toggle_entries", 1, 128'(o1_entries), 128'(5'd2));

    // Long run with limit disabled, random reads, explicit collision read.
    cyc(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      pcs[i] = $urandom & 32'hFFFF_FFFC;
      cyc(1'b1, pcs[i], 1'b1, (i == 50) ? 4'd0 : 4'($urandom_range(0, 15)), 1'b0);
      if (i == 50) begin
        chk("collide_valid", 1, 128'(o1_rd_valid), 128'(1'b1));
        chk("collide_pc",    1, 128'(o1_rd_pc), 128'(pcs[34]));
      end
    end
    chk("free_count",  1, 128'(o1_cycle_count), 128'(32'd100));
    chk("free_halted", 1, 128'(o1_halted), 128'(1'b0));
    chk("free_ovf",    1, 128'(o1_overflow), 128'(1'b1));

    // Randomised mix of captures, breakpoints, reads and resets.
    for (int i = 0; i < 400; i++) begin
      rst_r = ($urandom_range(0, 24) == 0);
      if (rst_r) begin
        bp_addr  = {32'($urandom_range(0, 31)) << 2, 32'($urandom_range(0, 31)) << 2};
        bp_valid = 2'($urandom_range(0, 3));
      end
      cyc(rst_r ? 1'b0 : 1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 31)) << 2,
          rst_r ? 1'b0 : 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rst_r);
    end
    cyc(1'b0, 32'd0, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 4'd0, 1'b0);
    chk("queue_drained", 0, 128'(q0.size() + q1.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
